// File: rtl/i2c_target_regfile.sv
// I2C target with a NUM_REGS x 8 register file, oversampling SCL/SDA on the system clock.
// Optional macro I2C_TARGET_AUTOINC_EN: pointer advances after every data byte.
module i2c_target_regfile #(
   parameter logic [6:0] ADDR        = 7'h2A,
   parameter int         NUM_REGS    = 8,
   parameter int         SYNC_STAGES = 2,
   localparam int        PW          = $clog2(NUM_REGS)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  scl_in,
   input  logic                  sda_in,
   output logic                  sda_oe,
   output logic [NUM_REGS*8-1:0] regs_out,
   output logic                  wr_strobe,
   output logic [PW-1:0]         wr_index,
   output logic                  busy
);

   typedef enum logic [2:0] {
      S_IDLE, S_ADDR, S_ACK, S_PTR, S_WDATA, S_RDATA, S_HACK, S_IGNORE
   } state_t;

   logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
   logic                   scl_d, sda_d;
   logic                   scl_s, sda_s;
   logic                   scl_rise, scl_fall, start_det, stop_det;

   state_t                 state, ack_next;
   logic [3:0]             cnt;
   logic [7:0]             shift, rx_byte, rd_byte;
   logic [PW-1:0]          ptr;
   logic                   host_ack;
   logic [NUM_REGS-1:0][7:0] regs;

   assign regs_out = regs;

   // Synchronisers reset to the idle-bus level so reset release never looks like START/STOP.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         scl_sync <= '1;
         sda_sync <= '1;
         scl_d    <= 1'b1;
         sda_d    <= 1'b1;
      end else begin
         scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_in};
         sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_in};
         scl_d    <= scl_sync[SYNC_STAGES-1];
         sda_d    <= sda_sync[SYNC_STAGES-1];
      end
   end

   assign scl_s     = scl_sync[SYNC_STAGES-1];
   assign sda_s     = sda_sync[SYNC_STAGES-1];
   assign scl_rise  = scl_s & ~scl_d;
   assign scl_fall  = ~scl_s & scl_d;
   assign start_det = scl_s & scl_d & sda_d & ~sda_s;
   assign stop_det  = scl_s & scl_d & ~sda_d & sda_s;
   assign rx_byte   = {shift[6:0], sda_s};

   function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
`ifdef I2C_TARGET_AUTOINC_EN
      return p + 1'b1;
`else
      return p;
`endif
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         ack_next  <= S_IDLE;
         cnt       <= '0;
         shift     <= '0;
         rd_byte   <= '0;
         ptr       <= '0;
         host_ack  <= 1'b0;
         regs      <= '0;
         sda_oe    <= 1'b0;
         wr_strobe <= 1'b0;
         wr_index  <= '0;
         busy      <= 1'b0;
      end else begin
         wr_strobe <= 1'b0;
         if (stop_det) begin
            state  <= S_IDLE;
            busy   <= 1'b0;
            sda_oe <= 1'b0;
         end else if (start_det) begin
            state  <= S_ADDR;
            cnt    <= '0;
            sda_oe <= 1'b0;
         end else begin
            case (state)
               S_ADDR: begin
                  if (scl_rise && cnt < 4'd8) begin
                     shift <= rx_byte;
                     cnt   <= cnt + 4'd1;
                     if (cnt == 4'd7) busy <= (rx_byte[7:1] == ADDR);
                  end else if (scl_fall && cnt == 4'd8) begin
                     if (shift[7:1] == ADDR) begin
                        sda_oe   <= 1'b1;
                        state    <= S_ACK;
                        ack_next <= shift[0] ? S_RDATA : S_PTR;
                     end else begin
                        state <= S_IGNORE;
                     end
                  end
               end
               S_ACK: begin
                  if (scl_fall) begin
                     state <= ack_next;
                     cnt   <= '0;
                     if (ack_next == S_RDATA) begin
                        rd_byte <= regs[ptr];
                        sda_oe  <= ~regs[ptr][7];
                     end else begin
                        sda_oe <= 1'b0;
                     end
                  end
               end
               S_PTR, S_WDATA: begin
                  if (scl_rise && cnt < 4'd8) begin
                     shift <= rx_byte;
                     cnt   <= cnt + 4'd1;
                     if (cnt == 4'd7) begin
                        if (state == S_PTR) begin
                           ptr <= rx_byte[PW-1:0];
                        end else begin
                           regs[ptr] <= rx_byte;
                           wr_strobe <= 1'b1;
                           wr_index  <= ptr;
                           ptr       <= ptr_next(ptr);
                        end
                     end
                  end else if (scl_fall && cnt == 4'd8) begin
                     sda_oe   <= 1'b1;
                     state    <= S_ACK;
                     ack_next <= S_WDATA;
                  end
               end
               S_RDATA: begin
                  // rd_byte shifts left so bit 6 is always the next bit to present.
                  if (scl_rise && cnt < 4'd8) begin
                     cnt <= cnt + 4'd1;
                  end else if (scl_fall && cnt == 4'd8) begin
                     sda_oe <= 1'b0;
                     ptr    <= ptr_next(ptr);
                     state  <= S_HACK;
                     cnt    <= '0;
                  end else if (scl_fall && cnt != 4'd0) begin
                     sda_oe  <= ~rd_byte[6];
                     rd_byte <= {rd_byte[6:0], 1'b0};
                  end
               end
               S_HACK: begin
                  if (scl_rise) begin
                     host_ack <= ~sda_s;
                     cnt      <= 4'd1;
                  end else if (scl_fall && cnt == 4'd1) begin
                     cnt <= '0;
                     if (host_ack) begin
                        state   <= S_RDATA;
                        rd_byte <= regs[ptr];
                        sda_oe  <= ~regs[ptr][7];
                     end else begin
                        state  <= S_IGNORE;
                        sda_oe <= 1'b0;
                     end
                  end
               end
               default: ;
            endcase
         end
      end
   end

endmodule
